// File: rtl/bitstream_packer_pkg.sv
// ---------------------------------------------------------------------------
// bitstream_packer_pkg : shared types and constants for the bitstream packer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bitstream_packer_pkg;

  typedef enum logic {
    FILL = 1'b0,
    PUSH = 1'b1
  } packer_state_t;

  localparam int BYTE_W = 8;

  // The transmitter holds dataRead high out of reset; matching it avoids a false pop
  localparam logic DATA_READ_RST = 1'b1;

endpackage

`default_nettype wire

// File: rtl/bitstream_packer_fifo.sv
// ---------------------------------------------------------------------------
// byte_fifo : byte FIFO with registered head, level and sticky overflow
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module byte_fifo
  import bitstream_packer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] head,
  output logic              not_empty,
  output logic              overflow,
  output logic [LVL_W-1:0]  level
);

  localparam int               AW         = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     rd_ptr_next;
  logic [LVL_W-1:0]  level_next;
  logic [BYTE_W-1:0] head_next;
  logic              do_push;
  logic              do_pop;

  always_comb begin
    do_pop      = pop && (level != '0);
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push
    do_push     = push && ((level != FULL_LEVEL) || do_pop);
    rd_ptr_next = rd_ptr + AW'(do_pop);
    level_next  = level + LVL_W'(do_push) - LVL_W'(do_pop);
    head_next   = head;
    if (level_next != '0) begin
      head_next = (do_push && (rd_ptr_next == wr_ptr)) ? push_data : mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      head      <= '0;
      not_empty <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr    <= rd_ptr_next;
      level     <= level_next;
      head      <= head_next;
      not_empty <= (level_next != '0);
      overflow  <= overflow | (push & ~do_push);
    end
  end

endmodule

`default_nettype wire

// File: rtl/bitstream_packer.sv
// ---------------------------------------------------------------------------
// bitstream_packer : packs delta-sigma bits into bytes for the UART transmitter
// Optional PACKER_INPUT_SYNC_EN adds 2-flop synchronizers on adcInput/dataRead
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bitstream_packer
  import bitstream_packer_pkg::*;
#(
  parameter int CLKS_PER_SAMPLE = 1,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        adcInput,
  input  logic                        dataRead,
  output logic [BYTE_W-1:0]           adcStream,
  output logic                        dataRdy,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifoLevel
);

  localparam int              DIV_W    = 8;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_SAMPLE - 1);

  logic adc_s;
  logic read_s;

`ifdef PACKER_INPUT_SYNC_EN
  logic [1:0] adc_sync;
  logic [1:0] read_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adc_sync  <= 2'b00;
      read_sync <= {2{DATA_READ_RST}};
    end else begin
      adc_sync  <= {adc_sync[0], adcInput};
      read_sync <= {read_sync[0], dataRead};
    end
  end

  assign adc_s  = adc_sync[1];
  assign read_s = read_sync[1];
`else
  assign adc_s  = adcInput;
  assign read_s = dataRead;
`endif

  logic [DIV_W-1:0]  div_cnt;
  logic              sample_en;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] shift;
  logic [BYTE_W-1:0] push_byte;
  logic              byte_done;
  logic              push;
  logic              read_prev;
  logic              pop_req;
  packer_state_t     state;
  packer_state_t     state_next;

  assign sample_en = (div_cnt == DIV_LAST);
  assign byte_done = sample_en && (bit_cnt == 3'd7);
  assign pop_req   = read_s & ~read_prev;

  // The byte offered to the FIFO already includes the bit captured on this edge
  always_comb begin
    push_byte          = shift;
    push_byte[bit_cnt] = adc_s;
  end

  always_comb begin
    state_next = FILL;
    unique case (state)
      FILL:    if (byte_done) state_next = PUSH;
      PUSH:    if (byte_done) state_next = PUSH;
      default: state_next = FILL;
    endcase
    push = (state_next == PUSH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FILL;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      read_prev <= DATA_READ_RST;
    end else begin
      state     <= state_next;
      div_cnt   <= sample_en ? '0 : div_cnt + DIV_W'(1);
      read_prev <= read_s;
      if (sample_en) begin
        shift   <= push_byte;
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_byte),
    .pop       (pop_req),
    .head      (adcStream),
    .not_empty (dataRdy),
    .overflow  (overflow),
    .level     (fifoLevel)
  );

endmodule

`default_nettype wire

// File: tb/tb_bitstream_packer.sv
// ---------------------------------------------------------------------------
// tb_bitstream_packer : scoreboard bench with a queue-based reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bitstream_packer;

  localparam int DEPTH = 4;
  localparam int CPS_A = 1;
  localparam int CPS_B = 5;
`ifdef PACKER_INPUT_SYNC_EN
  localparam int       SYNC_LAT   = 2;
  localparam logic [7:0] FIRST_BYTE = 8'h34;
`else
  localparam int       SYNC_LAT   = 0;
  localparam logic [7:0] FIRST_BYTE = 8'h4D;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, adc_in, data_read;
  logic [7:0] adc_stream;
  logic       data_rdy, ovf;
  logic [2:0] level;

  logic       rst_b, adc_b, read_b;
  logic [7:0] stream_b;
  logic       rdy_b, ovf_b;
  logic [2:0] level_b;

  int checks = 0;
  int errors = 0;
  bit b_done = 1'b0;

  bitstream_packer #(.CLKS_PER_SAMPLE(CPS_A), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .adcInput(adc_in), .dataRead(data_read),
    .adcStream(adc_stream), .dataRdy(data_rdy), .overflow(ovf), .fifoLevel(level)
  );

  bitstream_packer #(.CLKS_PER_SAMPLE(CPS_B), .FIFO_DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst(rst_b), .adcInput(adc_b), .dataRead(read_b),
    .adcStream(stream_b), .dataRdy(rdy_b), .overflow(ovf_b), .fifoLevel(level_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Reference model: bits gathered into bytes, FIFO as a byte queue
  typedef struct {
    logic       rdy;
    logic [7:0] head;
    logic [2:0] lvl;
    logic       ovf;
  } exp_t;

  exp_t       exp_q[$];
  int         m_cyc = 0;
  bit         m_bits[$];
  logic [7:0] m_fifo[$];
  logic [7:0] m_head = '0;
  bit         m_ovf = 1'b0;
  bit         m_prev = 1'b1;
  bit         a_hist[$];
  bit         r_hist[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cyc  = 0;
      m_bits.delete();
      m_fifo.delete();
      m_head = '0;
      m_ovf  = 1'b0;
      m_prev = 1'b1;
      exp_q.delete();
      a_hist.delete();
      r_hist.delete();
      for (int i = 0; i < SYNC_LAT; i++) begin
        a_hist.push_back(1'b0);
        r_hist.push_back(1'b1);
      end
    end else begin : step
      bit         a, r, push_now;
      logic [7:0] nb;
      a_hist.push_back(adc_in);
      r_hist.push_back(data_read);
      a        = a_hist.pop_front();
      r        = r_hist.pop_front();
      push_now = 1'b0;
      nb       = '0;
      if ((m_cyc + 1) % CPS_A == 0) begin
        m_bits.push_back(a);
        if (m_bits.size() == 8) begin
          foreach (m_bits[i]) nb[i] = m_bits[i];
          push_now = 1'b1;
          m_bits.delete();
        end
      end
      m_cyc++;
      if (r && !m_prev && m_fifo.size() > 0) void'(m_fifo.pop_front());
      m_prev = r;
      if (push_now) begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back(nb);
        else m_ovf = 1'b1;
      end
      if (m_fifo.size() > 0) m_head = m_fifo[0];
      exp_q.push_back('{rdy: (m_fifo.size() != 0), head: m_head,
                        lvl: 3'(m_fifo.size()), ovf: m_ovf});
    end
  end

  // Monitor: compares the DUT against the scoreboard every cycle
  always @(negedge clk) begin
    if (!rst) begin
      check("reset_rdy", data_rdy, 0);
      check("reset_level", level, 0);
      check("reset_stream", adc_stream, 0);
      check("reset_ovf", ovf, 0);
    end else if (exp_q.size() > 0) begin : cmp
      exp_t e;
      e = exp_q.pop_front();
      check("sb_rdy", data_rdy, e.rdy);
      check("sb_level", level, e.lvl);
      check("sb_ovf", ovf, e.ovf);
      check("sb_stream", adc_stream, e.head);
    end
  end

  // Main stimulus on the CLKS_PER_SAMPLE=1 instance
  initial begin : main
    logic [7:0] pat;
    int         n;
    pat       = 8'h4D;
    rst       = 1'b0;
    adc_in    = 1'b0;
    data_read = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      adc_in = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    #2 rst = 1'b0;
    @(negedge clk);
    check("midbyte_reset_level", level, 0);
    check("midbyte_reset_rdy", data_rdy, 0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      adc_in = pat[i];
      @(negedge clk);
      if (i == 6) check("first_byte_not_early", data_rdy, 0);
    end
    check("first_byte_rdy", data_rdy, 1);
    check("first_byte_value", adc_stream, FIRST_BYTE);

    repeat (20) begin
      adc_in = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    data_read = 1'b0;
    @(negedge clk);
    data_read = 1'b1;
    repeat (SYNC_LAT + 6) @(negedge clk);

    adc_in = 1'b1;
    n = 0;
    while (m_fifo.size() != DEPTH && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_timeout("wait_full");
    data_read = 1'b0;
    @(negedge clk);
    n = 0;
    while (m_bits.size() != 7 - SYNC_LAT && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) fail_timeout("wait_push_edge");
    data_read = 1'b1;
    repeat (SYNC_LAT + 1) @(negedge clk);
    check("full_pushpop_ovf", ovf, 0);
    check("full_pushpop_level", level, DEPTH);

    repeat (12) @(negedge clk);
    check("overflow_set", ovf, 1);
    check("overflow_level", level, DEPTH);
    repeat (4) begin
      data_read = 1'b0;
      @(negedge clk);
      data_read = 1'b1;
      @(negedge clk);
    end
    repeat (SYNC_LAT + 2) @(negedge clk);
    check("overflow_sticky", ovf, 1);

    #2 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int seg = 0; seg < 8; seg++) begin
      int pct;
      pct = int'($urandom_range(5, 60));
      repeat (200) begin
        adc_in = 1'($urandom_range(0, 1));
        if (int'($urandom_range(0, 99)) < pct) data_read = ~data_read;
        @(negedge clk);
      end
    end

    n = 0;
    while (!b_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!b_done) fail_timeout("divider_test_done");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Divider test on the CLKS_PER_SAMPLE=5 instance: value changes every 5 clocks,
  // with a one-clock glitch at each window start that no sample point sees
  initial begin : divider
    bit v;
    rst_b  = 1'b0;
    adc_b  = 1'b0;
    read_b = 1'b1;
    repeat (4) @(negedge clk);
    rst_b = 1'b1;
    for (int e = 0; e < 45; e++) begin
      v     = ((e / 5) % 2) == 1;
      adc_b = (e % 5 == 0) ? ~v : v;
      @(negedge clk);
      if (e == 38) check("div_not_early", rdy_b, 0);
      if (e == 39) begin
        check("div_byte_rdy", rdy_b, 1);
        check("div_byte_value", stream_b, 8'hAA);
        check("div_byte_level", level_b, 1);
      end
    end
    check("div_byte_held", stream_b, 8'hAA);
    check("div_no_overflow", ovf_b, 0);
    b_done = 1'b1;
  end

endmodule

`default_nettype wire
